// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer with valid/ready input handshake.
// Define PARITY_EN to append an even-parity bit after each word.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sval_q, sval_d;
    logic             fs_q, fs_d;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif

    logic             last_bit;
    logic             final_cycle;
    logic             xfer;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_sh;
    logic [WIDTH-1:0] adv_sh;

    assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
`ifdef PARITY_EN
    assign final_cycle = (state_q == PAR);
`else
    assign final_cycle = last_bit;
`endif

    // Gated by reset so the block never advertises ready while held in reset
    assign in_ready = reset && ((state_q == IDLE) || final_cycle);
    assign xfer     = in_valid && in_ready;

    assign first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign load_sh   = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
    assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign adv_sh    = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sout_d  = 1'b0;
        sval_d  = 1'b0;
        fs_d    = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        if (xfer) begin
            state_d = SHIFT;
            shreg_d = load_sh;
            cnt_d   = '0;
            sout_d  = first_bit;
            sval_d  = 1'b1;
            fs_d    = 1'b1;
`ifdef PARITY_EN
            par_d   = ^in_data;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                end
                SHIFT: begin
                    if (last_bit) begin
                        cnt_d = '0;
`ifdef PARITY_EN
                        state_d = PAR;
                        sout_d  = par_q;
                        sval_d  = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        shreg_d = adv_sh;
                        sout_d  = next_bit;
                        sval_d  = 1'b1;
                    end
                end
`ifdef PARITY_EN
                PAR: begin
                    state_d = IDLE;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            fs_q    <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            fs_q    <= fs_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign serial_out   = sout_q;
    assign serial_valid = sval_q;
    assign frame_start  = fs_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances driven in parallel,
// checked against a queue-of-output-bits model plus fixed vector tables.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         rdy1, so1, sv1, fs1, bz1;
    logic         rdy0, so0, sv0, fs0, bz0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .serial_out(so1), .serial_valid(sv1),
        .frame_start(fs1), .busy(bz1)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .serial_out(so0), .serial_valid(sv0),
        .frame_start(fs0), .busy(bz0)
    );

    // Model: queue of serial items still to be shown; head is the current cycle
    typedef struct {
        logic b;
        logic fs;
    } item_t;

    item_t q_msb[$];
    item_t q_lsb[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         so;
        logic         sv;
        logic         fs;
        logic         rdy;
        logic         so_lsb;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        item_t it;
        for (int k = 0; k < W; k++) begin
            it.fs = (k == 0);
            it.b  = d[W-1-k];
            q_msb.push_back(it);
            it.b  = d[k];
            q_lsb.push_back(it);
        end
`ifdef PARITY_EN
        it.fs = 1'b0;
        it.b  = ^d;
        q_msb.push_back(it);
        q_lsb.push_back(it);
`endif
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                        output logic s_so1, output logic s_sv1, output logic s_fs1,
                        output logic s_rdy1, output logic s_so0);
        logic erdy;
        logic xfer;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        in_data  = d;
        if (!r) begin
            q_msb.delete();
            q_lsb.delete();
        end
        #1;
        erdy = r && (q_msb.size() <= 1);
        chk("msb_ready", rdy1, erdy);
        chk("lsb_ready", rdy0, erdy);
        chk("msb_busy", bz1, q_msb.size() > 0);
        chk("lsb_busy", bz0, q_lsb.size() > 0);
        chk("msb_valid", sv1, q_msb.size() > 0);
        chk("lsb_valid", sv0, q_lsb.size() > 0);
        chk("msb_sout", so1, q_msb.size() > 0 ? q_msb[0].b : 1'b0);
        chk("lsb_sout", so0, q_lsb.size() > 0 ? q_lsb[0].b : 1'b0);
        chk("msb_fs", fs1, q_msb.size() > 0 ? q_msb[0].fs : 1'b0);
        chk("lsb_fs", fs0, q_lsb.size() > 0 ? q_lsb[0].fs : 1'b0);
        s_so1  = so1;
        s_sv1  = sv1;
        s_fs1  = fs1;
        s_rdy1 = rdy1;
        s_so0  = so0;
        xfer = v && erdy;
        @(posedge clk);
        if (r) begin
            if (q_msb.size() > 0) begin
                void'(q_msb.pop_front());
                void'(q_lsb.pop_front());
            end
            if (xfer) push_word(d);
        end
    endtask

    task automatic add(input logic v, input logic [W-1:0] d, input logic so,
                       input logic sv, input logic fs, input logic rdy,
                       input logic sl);
        vec_t e;
        e.v = v; e.d = d; e.so = so; e.sv = sv;
        e.fs = fs; e.rdy = rdy; e.so_lsb = sl;
        tbl.push_back(e);
    endtask

    initial begin
        logic a, b, c, e, f;
        logic pv;
        logic [W-1:0] pd;
        logic pend;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'b1011;

        // Reset held with in_valid high: nothing may be accepted
        step(1'b0, 1'b1, 4'b1011, a, b, c, e, f);
        step(1'b0, 1'b1, 4'b1011, a, b, c, e, f);
        chk("rst_ready", e, 1'b0);
        chk("rst_valid", b, 1'b0);
        step(1'b1, 1'b0, 4'b0000, a, b, c, e, f);
        chk("post_rst_ready", e, 1'b1);
        chk("post_rst_busy", bz1, 1'b0);

        // Back-to-back 1011 then 0110
        add(1, 4'b1011, 0, 0, 0, 1, 0);
        add(1, 4'b0110, 1, 1, 1, 0, 1);
        add(1, 4'b0110, 0, 1, 0, 0, 1);
        add(1, 4'b0110, 1, 1, 0, 0, 0);
`ifdef PARITY_EN
        add(1, 4'b0110, 1, 1, 0, 0, 1);
        add(1, 4'b0110, 1, 1, 0, 1, 1);
`else
        add(1, 4'b0110, 1, 1, 0, 1, 1);
`endif
        add(0, 4'b0000, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 1, 1, 0, 0, 1);
        add(0, 4'b0000, 1, 1, 0, 0, 1);
`ifdef PARITY_EN
        add(0, 4'b0000, 0, 1, 0, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 1, 0);
`else
        add(0, 4'b0000, 0, 1, 0, 1, 0);
`endif
        add(0, 4'b0000, 0, 0, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].v, tbl[i].d, a, b, c, e, f);
            chk($sformatf("tbl%0d_sout", i), a, tbl[i].so);
            chk($sformatf("tbl%0d_valid", i), b, tbl[i].sv);
            chk($sformatf("tbl%0d_fs", i), c, tbl[i].fs);
            chk($sformatf("tbl%0d_ready", i), e, tbl[i].rdy);
            chk($sformatf("tbl%0d_lsb", i), f, tbl[i].so_lsb);
        end

        // Reset in the middle of 1111, after two bits have been shown
        step(1'b1, 1'b1, 4'b1111, a, b, c, e, f);
        step(1'b1, 1'b0, 4'b0000, a, b, c, e, f);
        chk("mid_bit0", b, 1'b1);
        step(1'b1, 1'b0, 4'b0000, a, b, c, e, f);
        chk("mid_bit1", b, 1'b1);
        step(1'b0, 1'b0, 4'b0000, a, b, c, e, f);
        chk("mid_rst_valid", b, 1'b0);
        chk("mid_rst_sout", a, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 4'b0000, a, b, c, e, f);
            chk("post_mid_valid", b, 1'b0);
        end

        // Random traffic; data held stable while a request is pending
        pend = 1'b0;
        pv   = 1'b0;
        pd   = '0;
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 79) != 0);
            if (!pend) begin
                pv = ($urandom_range(0, 9) < 6);
                pd = W'($urandom);
            end
            pend = pv && !(r && q_msb.size() <= 1);
            if (!r) pend = 1'b0;
            step(r, pv, pd, a, b, c, e, f);
        end

        step(1'b1, 1'b0, 4'b0000, a, b, c, e, f);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
